// File: rtl/fire_ctrl_pkg.sv
// Shared types, defaults and the round-robin search helper for the
// fire alarm sequencer and its input sampler.
package fire_ctrl_pkg;

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    localparam int MAX_CH = 16;

    localparam int DEF_OUT_W = 11;
    localparam logic [DEF_OUT_W-1:0] DEF_IDLE_CODE = 11'h000;

    // Channel i occupies bits [i*OUT_W +: OUT_W], so channel 0 (0x088)
    // sits in the least significant slot.
    localparam logic [4*DEF_OUT_W-1:0] DEF_CODE_TABLE =
        {11'h401, 11'h202, 11'h104, 11'h088};

    // First set bit of mask strictly after cur, wrapping modulo n.
    // cur itself is found last, so a sole pending channel keeps itself.
    function automatic logic [3:0] next_pending(
        input logic [MAX_CH-1:0] mask,
        input logic [3:0]        cur,
        input int                n
    );
        logic [3:0] res;
        logic       found;
        int         idx;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= MAX_CH; k++) begin
            idx = (int'(cur) + k) % n;
            if (k <= n && !found && mask[idx[3:0]]) begin
                res   = idx[3:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fire_alarm_sequencer_sample_sync.sv
// One sensor channel: two-flop synchronisers on sensor and strobe plus
// strobe rising-edge detect. Ports: clk, reset_n, sensor, sample_en -> set.
module sample_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic sensor,
    input  logic sample_en,
    output logic set
);

    logic sens_q1;
    logic sens_q2;
    logic en_q1;
    logic en_q2;
    logic en_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sens_q1 <= 1'b0;
            sens_q2 <= 1'b0;
            en_q1   <= 1'b0;
            en_q2   <= 1'b0;
            en_prev <= 1'b0;
        end else begin
            sens_q1 <= sensor;
            sens_q2 <= sens_q1;
            en_q1   <= sample_en;
            en_q2   <= en_q1;
            en_prev <= en_q2;
        end
    end

    // Only a strobe rise with the sensor active raises an alarm; a low
    // sensor on a strobe leaves the sticky bit alone.
    assign set = en_q2 & ~en_prev & sens_q2;

endmodule

// File: rtl/fire_alarm_sequencer.sv
// Sticky N-channel alarm latch with round-robin display of pending codes.
// Ports: clk, reset_n, sensor, sample_en, ack -> Y, alarm, active_ch, pending.
// Option FIRE_PRIORITY_PREEMPT_EN: pending ch0 pins the display to ch0.
module fire_alarm_sequencer
    import fire_ctrl_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int OUT_W        = DEF_OUT_W,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter logic [N_CH*OUT_W-1:0] CODE_TABLE = DEF_CODE_TABLE,
    parameter logic [OUT_W-1:0]      IDLE_CODE  = DEF_IDLE_CODE
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_CH-1:0]         sensor,
    input  logic [N_CH-1:0]         sample_en,
    input  logic                    ack,
    output logic [OUT_W-1:0]        Y,
    output logic                    alarm,
    output logic [$clog2(N_CH)-1:0] active_ch,
    output logic [N_CH-1:0]         pending
);

    localparam int CHW = $clog2(N_CH);
    localparam int CW  = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DWELL_CYCLES - 1);

    state_t           state, state_n;
    logic [CHW-1:0]   cur, cur_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [N_CH-1:0]  pend, pend_n;
    logic             adv, adv_n;
    logic [OUT_W-1:0] y_n;
    logic             alarm_n;

    logic [N_CH-1:0]   set;
    logic [MAX_CH-1:0] mask;
    logic [3:0]        cur4;
    logic [CHW-1:0]    first_ch;
    logic [CHW-1:0]    rr_ch;
    logic [N_CH-1:0]   cur_mask;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sample_sync u_sync (
            .clk       (clk),
            .reset_n   (reset_n),
            .sensor    (sensor[i]),
            .sample_en (sample_en[i]),
            .set       (set[i])
        );
    end

    always_comb begin
        mask = '0;
        mask[N_CH-1:0] = pend;
        cur4 = '0;
        cur4[CHW-1:0] = cur;
    end

    assign first_ch = CHW'(next_pending(mask, 4'(N_CH - 1), N_CH));
    assign rr_ch    = CHW'(next_pending(mask, cur4, N_CH));
    assign cur_mask = N_CH'(1) << cur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cur   <= '0;
            cnt   <= '0;
            pend  <= '0;
            adv   <= 1'b0;
            Y     <= IDLE_CODE;
            alarm <= 1'b0;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            cnt   <= cnt_n;
            pend  <= pend_n;
            adv   <= adv_n;
            Y     <= y_n;
            alarm <= alarm_n;
        end
    end

    always_comb begin
        state_n = state;
        cur_n   = cur;
        cnt_n   = cnt;
        adv_n   = 1'b0;
        pend_n  = pend | set;
        unique case (state)
            IDLE: begin
                cur_n = '0;
                cnt_n = '0;
                if (pend != '0) begin
                    state_n = SHOW;
                    cur_n   = first_ch;
                end
            end
            SHOW: begin
                if (adv) begin
                    // Edge after an ack: move on, or drop to idle.
                    cnt_n = '0;
                    if (pend == '0) begin
                        state_n = IDLE;
                        cur_n   = '0;
                    end else begin
                        cur_n = rr_ch;
                    end
                end else if (ack) begin
                    // A simultaneous set re-arms the channel.
                    pend_n = (pend & ~cur_mask) | set;
                    cnt_n  = '0;
                    adv_n  = 1'b1;
                end else if (cnt == TERM) begin
                    cnt_n = '0;
                    cur_n = rr_ch;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
`ifdef FIRE_PRIORITY_PREEMPT_EN
                if (pend[0] && !adv_n && state_n == SHOW) begin
                    if (cur != '0) begin
                        cnt_n = '0;
                    end
                    cur_n = '0;
                end
`endif
            end
            default: begin
                state_n = IDLE;
                cur_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        y_n     = IDLE_CODE;
        alarm_n = 1'b0;
        if (state_n == SHOW) begin
            y_n     = CODE_TABLE[int'(cur_n)*OUT_W +: OUT_W];
            alarm_n = 1'b1;
        end
    end

    assign active_ch = cur;
    assign pending   = pend;

endmodule

// File: tb/tb_fire_alarm_sequencer.sv
// Scoreboard bench for fire_alarm_sequencer with a short dwell period.
// Expected output snapshots are queued with stimulus and popped on compare.
module tb_fire_alarm_sequencer;

    localparam int N  = 4;
    localparam int W  = 11;
    localparam int DW = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] sensor = '0;
    logic [N-1:0] sample_en = '0;
    logic         ack = 1'b0;
    logic [W-1:0] Y;
    logic         alarm;
    logic [1:0]   active_ch;
    logic [N-1:0] pending;

    typedef struct packed {
        logic [W-1:0] y;
        logic         al;
        logic [1:0]   ch;
        logic [N-1:0] pend;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    fire_alarm_sequencer #(
        .N_CH         (N),
        .OUT_W        (W),
        .DWELL_CYCLES (DW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sensor    (sensor),
        .sample_en (sample_en),
        .ack       (ack),
        .Y         (Y),
        .alarm     (alarm),
        .active_ch (active_ch),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] y, input logic al,
                        input logic [1:0] ch, input logic [N-1:0] p);
        exp_t e;
        e.y    = y;
        e.al   = al;
        e.ch   = ch;
        e.pend = p;
        sb_q.push_back(e);
    endtask

    task automatic pop(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, ".empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".y"}, 32'(Y), 32'(e.y));
            check({tag, ".alarm"}, 32'(alarm), 32'(e.al));
            check({tag, ".ch"}, 32'(active_ch), 32'(e.ch));
            check({tag, ".pend"}, 32'(pending), 32'(e.pend));
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    initial begin
        #1;
        push(11'h000, 0, 0, 4'b0000); pop("rst");
        step(2);
        reset_n = 1'b1;
        step(3);
        push(11'h000, 0, 0, 4'b0000); pop("release");

        sensor = 4'b0100; sample_en = 4'b0100;
        step(3);
        push(11'h000, 0, 0, 4'b0100); pop("c2_pend");
        step(1);
        push(11'h202, 1, 2, 4'b0100); pop("c2_show");
        step(10);
        push(11'h202, 1, 2, 4'b0100); pop("c2_hold");
        sample_en = '0;
        step(3);
        sensor = 4'b0000; sample_en = 4'b0100;
        step(5);
        push(11'h202, 1, 2, 4'b0100); pop("c2_sticky");
        sample_en = '0;

        pulse_ack();
        push(11'h202, 1, 2, 4'b0000); pop("ack2_edge");
        step(1);
        push(11'h000, 0, 0, 4'b0000); pop("ack2_idle");
        pulse_ack();
        step(2);
        push(11'h000, 0, 0, 4'b0000); pop("idle_ack");

        sensor = 4'b1010; sample_en = 4'b1010;
        step(4);
        push(11'h104, 1, 1, 4'b1010); pop("rr_ch1");
        step(3);
        push(11'h104, 1, 1, 4'b1010); pop("rr_ch1_dwell");
        step(1);
        push(11'h401, 1, 3, 4'b1010); pop("rr_ch3");
        step(3);
        push(11'h401, 1, 3, 4'b1010); pop("rr_ch3_dwell");
        step(1);
        push(11'h104, 1, 1, 4'b1010); pop("rr_wrap");
        pulse_ack();
        push(11'h104, 1, 1, 4'b1000); pop("ack1_edge");
        step(1);
        push(11'h401, 1, 3, 4'b1000); pop("ack1_next");
        pulse_ack();
        push(11'h401, 1, 3, 4'b0000); pop("ack3_edge");
        step(1);
        push(11'h000, 0, 0, 4'b0000); pop("ack3_idle");

        sample_en = '0;
        step(3);
        sensor = 4'b0100; sample_en = 4'b0100;
        step(4);
        push(11'h202, 1, 2, 4'b0100); pop("c2_again");
        sample_en = '0;
        step(3);
        sample_en = 4'b0100;
        step(2);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        push(11'h202, 1, 2, 4'b0100); pop("setack_edge");
        step(1);
        push(11'h202, 1, 2, 4'b0100); pop("setack_next");

        step(2);
        #2 reset_n = 1'b0;
        #1;
        push(11'h000, 0, 0, 4'b0000); pop("async_rst");
        sample_en = '0;
        sensor = '0;
        step(2);
        reset_n = 1'b1;
        step(4);
        push(11'h000, 0, 0, 4'b0000); pop("post_rst");

        sensor = 4'b0101; sample_en = 4'b0100;
        step(4);
        push(11'h202, 1, 2, 4'b0100); pop("pre_c2");
        sample_en = 4'b0101;
        step(3);
`ifdef FIRE_PRIORITY_PREEMPT_EN
        push(11'h202, 1, 2, 4'b0101); pop("pre_pend");
        step(1);
        push(11'h088, 1, 0, 4'b0101); pop("pre_ch0");
        step(8);
        push(11'h088, 1, 0, 4'b0101); pop("pre_hold");
        pulse_ack();
        push(11'h088, 1, 0, 4'b0100); pop("pre_ack_edge");
        step(1);
        push(11'h202, 1, 2, 4'b0100); pop("pre_resume");
`else
        check("pend_c0", 32'(pending), 32'(4'b0101));
        push(11'h088, 1, 0, 4'b0101);
        for (int i = 0; i < 2 * DW; i++) begin
            if (Y != 11'h088) step(1);
        end
        pop("wrap_to_c0");
        step(DW);
        push(11'h202, 1, 2, 4'b0101); pop("wrap_to_c2");
`endif

        if (sb_q.size() != 0) check("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
